// File: rtl/i_cache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Serves one fetch at a time; misses refill a single word from the memory controller.
module i_cache #(
   parameter int unsigned INDEX_BITS = 8,
   parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        fetch2iCache_enable,
   input  logic [31:0] fetch2iCache_address,
   output logic        iCache2fetch_enable,
   output logic [31:0] iCache2fetch_return,
   output logic [31:0] iCache2fetch_pc,
   output logic        iCache2mem_enable,
   output logic [31:0] iCache2mem_address,
   input  logic        mem2iCache_enable,
   input  logic [31:0] mem2iCache_data
);

   localparam int unsigned Lines = 1 << INDEX_BITS;

   typedef enum logic [1:0] {StIdle, StMiss, StResp} state_e;

   state_e state_q, state_d;

   logic [31:0] req_addr_q, req_addr_d;
   logic        drop_q, drop_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic [31:0] resp_pc_q, resp_pc_d;

   logic [31:0]         data_q [Lines];
   logic [TAG_BITS-1:0] tag_q  [Lines];
   logic [Lines-1:0]    valid_q;

   logic [INDEX_BITS-1:0] fetch_idx, req_idx;
   logic [TAG_BITS-1:0]   fetch_tag, req_tag;
   logic [31:0]           fetch_word_addr;
   logic                  accept, hit, refill;
   logic                  unused_addr_lsbs;

   assign fetch_idx       = fetch2iCache_address[INDEX_BITS+1:2];
   assign fetch_tag       = fetch2iCache_address[31:INDEX_BITS+2];
   assign fetch_word_addr = {fetch2iCache_address[31:2], 2'b00};
   assign req_idx         = req_addr_q[INDEX_BITS+1:2];
   assign req_tag         = req_addr_q[31:INDEX_BITS+2];
   assign unused_addr_lsbs = ^fetch2iCache_address[1:0];

   assign accept = (state_q == StIdle) && fetch2iCache_enable && !clear;
   assign hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
   assign refill = (state_q == StMiss) && mem2iCache_enable;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         req_addr_q  <= '0;
         drop_q      <= 1'b0;
         resp_data_q <= '0;
         resp_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         drop_q      <= drop_d;
         resp_data_q <= resp_data_d;
         resp_pc_q   <= resp_pc_d;
      end
   end

   // Data and tag arrays need no reset; valid bits gate every lookup
   always_ff @(posedge clk) begin
      if (refill && !rst) begin
         data_q[req_idx] <= mem2iCache_data;
         tag_q[req_idx]  <= req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (refill) begin
         valid_q[req_idx] <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      drop_d      = drop_q;
      resp_data_d = resp_data_q;
      resp_pc_d   = resp_pc_q;
      unique case (state_q)
         StIdle: begin
            drop_d = 1'b0;
            if (accept) begin
               req_addr_d = fetch_word_addr;
               if (hit) begin
                  resp_data_d = data_q[fetch_idx];
                  resp_pc_d   = fetch_word_addr;
                  state_d     = StResp;
               end else begin
                  state_d = StMiss;
               end
            end
         end
         StMiss: begin
            if (clear) begin
               drop_d = 1'b1;
            end
            if (mem2iCache_enable) begin
               // A flushed request still installs its line but produces no response
               if (drop_q || clear) begin
                  state_d = StIdle;
                  drop_d  = 1'b0;
               end else begin
                  resp_data_d = mem2iCache_data;
                  resp_pc_d   = req_addr_q;
                  state_d     = StResp;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
            drop_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
            drop_d  = 1'b0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      iCache2fetch_enable = (state_q == StResp) && !clear;
      iCache2fetch_return = resp_data_q;
      iCache2fetch_pc     = resp_pc_q;
      iCache2mem_enable   = (state_q == StMiss);
      iCache2mem_address  = req_addr_q;
   end

endmodule
